// File: rtl/streebog_pkg.sv
// Shared constants, state encoding and helpers for the Streebog message packer.
package streebog_pkg;

    localparam int N_FULL   = 512;
    localparam int IN_WIDTH = 64;
    localparam int WORDS    = N_FULL / IN_WIDTH;
    localparam int BYTES    = N_FULL / 8;
    localparam int WCNT_W   = $clog2(WORDS);

    // Block emitted for an empty tail: only the 0x01 marker in byte 0.
    localparam logic [N_FULL-1:0] PAD_BLOCK = N_FULL'(1);

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_FILL,
        PK_PAD,
        PK_DRAIN
    } pk_state_t;

    // Byte counts above a full beat are treated as a full beat.
    function automatic logic [3:0] clamp_bytes(input logic [3:0] bytes);
        return (bytes > 4'd8) ? 4'd8 : bytes;
    endfunction

endpackage

// File: rtl/streebog_pad.sv
// Combinational tail padding: keep bytes below L, write 0x01 at byte L, zero the rest.
module streebog_pad
    import streebog_pkg::*;
(
    input  logic [N_FULL-1:0] block_i,
    input  logic [6:0]        len_bytes_i,
    output logic [N_FULL-1:0] block_o,
    output logic [9:0]        len_bits_o
);

    // Per-byte select between message data, the 0x01 marker and zero.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        block_o = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (7'(i) < len_bytes_i) begin
                block_o[8*i +: 8] = block_i[8*i +: 8];
            end else if (7'(i) == len_bytes_i) begin
                block_o[8*i +: 8] = 8'h01;
            end
        end
    end

    assign len_bits_o = {len_bytes_i, 3'b000};

endmodule

// File: rtl/streebog_msg_packer.sv
// Streebog message packer: 64-bit beats into 512-bit blocks, padded final block,
// two-deep buffering (assembly register plus output register).
module streebog_msg_packer #(
    parameter int DATA_WIDTH = 512,
    parameter int IN_WIDTH   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IN_WIDTH-1:0]   in_data_i,
    input  logic [3:0]            in_bytes_i,
    input  logic                  in_last_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] message_o,
    output logic                  mes_last_o,
    output logic [9:0]            mes_last_len_o,
    output logic                  mes_valid_o,
    input  logic                  mes_ready_i,
    output logic                  fsm_start_req_o
);
    import streebog_pkg::*;

    pk_state_t         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [N_FULL-1:0] asm_q, asm_d;
    logic              asm_full_q, asm_full_d;
    logic              asm_last_q, asm_last_d;
    logic [9:0]        asm_len_q, asm_len_d;
    logic [N_FULL-1:0] msg_q, msg_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [9:0]        out_len_q, out_len_d;
    logic              start_q, start_d;
    logic              hold_q, hold_d;

    logic              beat_acc;
    logic              out_acc;
    logic              out_free;
    logic [3:0]        beat_bytes;
    logic [6:0]        total_bytes;
    logic              full_block;
    logic              short_last;
    logic              block_done;
    logic [N_FULL-1:0] merged;
    logic [N_FULL-1:0] padded;
    logic [9:0]        padded_len;
    logic [N_FULL-1:0] nb_data;
    logic              nb_last;
    logic [9:0]        nb_len;

    // Beats are taken only while filling, with no parked block and not in the
    // one-cycle gap that lets the core see fsm_start_req drop.
    assign in_ready_o = !rst_i && (state_q == PK_IDLE || state_q == PK_FILL)
                        && !asm_full_q && !hold_q;
    assign beat_acc   = in_valid_i && in_ready_o;
    assign out_acc    = out_valid_q && mes_ready_i;
    assign out_free   = !out_valid_q || mes_ready_i;

    // L = bytes of the current block including this beat; non-last beats are full.
    assign beat_bytes  = in_last_i ? clamp_bytes(in_bytes_i) : 4'd8;
    assign total_bytes = 7'({wcnt_q, 3'b000}) + 7'(beat_bytes);
    assign full_block  = (total_bytes == 7'd64);
    assign short_last  = in_last_i && !full_block;
    assign block_done  = full_block || short_last;

    // Current assembly contents with the incoming beat dropped into its word slot.
    always_comb begin
        merged = asm_q;
        merged[wcnt_q*IN_WIDTH +: IN_WIDTH] = in_data_i;
    end

    streebog_pad u_pad (
        .block_i     (merged),
        .len_bytes_i (total_bytes),
        .block_o     (padded),
        .len_bits_o  (padded_len)
    );

    // A block closed by this beat: raw when full, padded when it is a short tail.
    assign nb_data = short_last ? padded : merged;
    assign nb_last = short_last;
    assign nb_len  = short_last ? padded_len : '0;

    // Next-state logic for the packer FSM, the assembly side and the output register.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        asm_d       = asm_q;
        asm_full_d  = asm_full_q;
        asm_last_d  = asm_last_q;
        asm_len_d   = asm_len_q;
        msg_d       = msg_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_len_d   = out_len_q;
        start_d     = start_q;
        hold_d      = 1'b0;

        if (out_acc) begin
            out_valid_d = 1'b0;
        end

        if (beat_acc) begin
            start_d = 1'b1;
            asm_d   = merged;
            if (block_done) begin
                wcnt_d = '0;
                if (out_free) begin
                    msg_d       = nb_data;
                    out_valid_d = 1'b1;
                    out_last_d  = nb_last;
                    out_len_d   = nb_len;
                end else begin
                    asm_d      = nb_data;
                    asm_full_d = 1'b1;
                    asm_last_d = nb_last;
                    asm_len_d  = nb_len;
                end
                if (in_last_i) begin
                    state_d = full_block ? PK_PAD : PK_DRAIN;
                end else begin
                    state_d = PK_FILL;
                end
            end else begin
                wcnt_d  = wcnt_q + 1'b1;
                state_d = PK_FILL;
            end
        end else if (asm_full_q && out_free) begin
            msg_d       = asm_q;
            out_valid_d = 1'b1;
            out_last_d  = asm_last_q;
            out_len_d   = asm_len_q;
            asm_full_d  = 1'b0;
        end else if (state_q == PK_PAD && !asm_full_q && out_free) begin
            msg_d       = PAD_BLOCK;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            out_len_d   = '0;
            state_d     = PK_DRAIN;
        end

        if (out_acc && out_last_q) begin
            state_d = PK_IDLE;
            start_d = 1'b0;
            hold_d  = 1'b1;
        end
    end

    // Control and output registers, all cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q     <= PK_IDLE;
            wcnt_q      <= '0;
            asm_full_q  <= 1'b0;
            asm_last_q  <= 1'b0;
            asm_len_q   <= '0;
            msg_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_len_q   <= '0;
            start_q     <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            asm_full_q  <= asm_full_d;
            asm_last_q  <= asm_last_d;
            asm_len_q   <= asm_len_d;
            msg_q       <= msg_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_len_q   <= out_len_d;
            start_q     <= start_d;
            hold_q      <= hold_d;
        end
    end

    // Assembly data register.
    always_ff @(posedge clk_i) begin
        // NOTE: wide data storage is left unreset; wcnt_q, asm_full_q and the pad mask decide which bits matter.
        asm_q <= asm_d;
    end

    assign message_o       = msg_q;
    assign mes_last_o      = out_last_q;
    assign mes_last_len_o  = out_len_q;
    assign mes_valid_o     = out_valid_q;
    assign fsm_start_req_o = start_q;

endmodule
